// File: rtl/trace_pkg.sv
// Shared types and helpers for the commit trace path: input request bundles,
// the trace record layout, slot ordering and per-slot record formatting.
package trace_pkg;

  localparam int TRACE_SLOTS = 6;

  // Emission order within one commit cycle; a lower index is emitted first.
  localparam logic [2:0] SLOT_MEM_A = 3'd0;
  localparam logic [2:0] SLOT_REG1  = 3'd1;
  localparam logic [2:0] SLOT_HILO1 = 3'd2;
  localparam logic [2:0] SLOT_MEM_B = 3'd3;
  localparam logic [2:0] SLOT_REG2  = 3'd4;
  localparam logic [2:0] SLOT_HILO2 = 3'd5;

  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_HILO = 2'd1,
    KIND_MEM  = 2'd2
  } TraceKind_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;

  typedef struct packed {
    logic        we;
    logic [63:0] hilo;
  } HiloWriteReq_t;

  typedef struct packed {
    TraceKind_t  kind;
    logic        pipe;
    logic [15:0] addr;
    logic [63:0] data;
    logic [31:0] cycle;
  } TraceRecord_t;

  // Everything the pipeline presents in one commit cycle.
  typedef struct packed {
    RegWriteReq_t  reg_a;
    RegWriteReq_t  reg_b;
    HiloWriteReq_t hilo_a;
    HiloWriteReq_t hilo_b;
    logic          mem_we_a;
    logic          mem_we_b;
    logic [31:0]   mem_addr_a;
    logic [31:0]   mem_addr_b;
    logic [31:0]   mem_data_a;
    logic [31:0]   mem_data_b;
  } CommitBundle_t;

  // Which slots of a bundle carry a real event; writes to r0 are discarded.
  function automatic logic [TRACE_SLOTS-1:0] slot_vector(input CommitBundle_t b);
    logic [TRACE_SLOTS-1:0] v;
    v             = '0;
    v[SLOT_MEM_A] = b.mem_we_a;
    v[SLOT_REG1]  = b.reg_a.we && (b.reg_a.waddr != 5'd0);
    v[SLOT_HILO1] = b.hilo_a.we;
    v[SLOT_MEM_B] = b.mem_we_b;
    v[SLOT_REG2]  = b.reg_b.we && (b.reg_b.waddr != 5'd0);
    v[SLOT_HILO2] = b.hilo_b.we;
    return v;
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] lowest_slot(input logic [TRACE_SLOTS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = TRACE_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Format one slot of a bundle as a trace record carrying the given stamp.
  function automatic TraceRecord_t slot_record(input CommitBundle_t b,
                                               input logic [2:0]    slot,
                                               input logic [31:0]   stamp);
    TraceRecord_t rec;
    rec       = '0;
    rec.cycle = stamp;
    case (slot)
      SLOT_MEM_A: begin
        rec.kind = KIND_MEM;
        rec.pipe = 1'b0;
        rec.addr = {b.mem_addr_a[15:2], 2'b00};
        rec.data = {32'h0, b.mem_data_a};
      end
      SLOT_REG1: begin
        rec.kind = KIND_REG;
        rec.pipe = 1'b0;
        rec.addr = {11'h0, b.reg_a.waddr};
        rec.data = {32'h0, b.reg_a.wdata};
      end
      SLOT_HILO1: begin
        rec.kind = KIND_HILO;
        rec.pipe = 1'b0;
        rec.data = b.hilo_a.hilo;
      end
      SLOT_MEM_B: begin
        rec.kind = KIND_MEM;
        rec.pipe = 1'b1;
        rec.addr = {b.mem_addr_b[15:2], 2'b00};
        rec.data = {32'h0, b.mem_data_b};
      end
      SLOT_REG2: begin
        rec.kind = KIND_REG;
        rec.pipe = 1'b1;
        rec.addr = {11'h0, b.reg_b.waddr};
        rec.data = {32'h0, b.reg_b.wdata};
      end
      SLOT_HILO2: begin
        rec.kind = KIND_HILO;
        rec.pipe = 1'b1;
        rec.data = b.hilo_b.hilo;
      end
      default: ;
    endcase
    return rec;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO. The head is read straight out of the storage
// registers and forced to zero while empty, so it is stable until popped.
module trace_fifo import trace_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  TraceRecord_t push_rec,
  input  logic         pop_i,
  output TraceRecord_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  TraceRecord_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; a pop never makes room for a same-cycle push.
  always_comb begin
    do_push  = push_i && !full;
    do_pop   = pop_i && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state, cleared asynchronously so a reset drops everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are only ever observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_rec;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Turns each commit cycle of both pipes into an ordered stream of trace
// records. A multi-event cycle is captured once and then drained one record
// per cycle while stall_o holds the pipeline.
module commit_trace_buffer import trace_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  RegWriteReq_t  reg_wr1,
  input  RegWriteReq_t  reg_wr2,
  input  HiloWriteReq_t hilo_wr1,
  input  HiloWriteReq_t hilo_wr2,
  input  logic          mem_we_a,
  input  logic          mem_we_b,
  input  logic [31:0]   mem_addr_a,
  input  logic [31:0]   mem_addr_b,
  input  logic [31:0]   mem_data_a,
  input  logic [31:0]   mem_data_b,
  output logic          stall_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_kind,
  output logic          out_pipe,
  output logic [15:0]   out_addr,
  output logic [63:0]   out_data,
  output logic [31:0]   out_cycle,
  output logic [31:0]   event_count
);

  CommitBundle_t          in_bundle, src_bundle, bundle_q, bundle_d;
  logic [TRACE_SLOTS-1:0] in_vec, work_vec, sel_mask, pending_q, pending_d;
  logic [31:0]            stamp_q, stamp_d;
  logic [31:0]            cycle_ctr_q, cycle_ctr_d;
  logic [31:0]            event_count_q, event_count_d;
  logic [2:0]             sel;
  logic                   accept, push, fifo_full, fifo_empty;
  TraceRecord_t           push_rec, head_rec;

  assign in_bundle = '{reg_a: reg_wr1, reg_b: reg_wr2,
                       hilo_a: hilo_wr1, hilo_b: hilo_wr2,
                       mem_we_a: mem_we_a, mem_we_b: mem_we_b,
                       mem_addr_a: mem_addr_a, mem_addr_b: mem_addr_b,
                       mem_data_a: mem_data_a, mem_data_b: mem_data_b};

  // With nothing pending, serve the live bundle; otherwise drain the held one.
  always_comb begin
    in_vec        = slot_vector(in_bundle);
    accept        = (pending_q == '0);
    work_vec      = accept ? in_vec : pending_q;
    src_bundle    = accept ? in_bundle : bundle_q;
    sel           = lowest_slot(work_vec);
    sel_mask      = '0;
    sel_mask[sel] = 1'b1;
    push          = !fifo_full && (work_vec != '0);
    push_rec      = slot_record(src_bundle, sel, accept ? cycle_ctr_q : stamp_q);
    pending_d     = pending_q;
    bundle_d      = bundle_q;
    stamp_d       = stamp_q;
    if (push) begin
      pending_d = work_vec & ~sel_mask;
      if (accept) begin
        bundle_d = in_bundle;
        stamp_d  = cycle_ctr_q;
      end
    end
    cycle_ctr_d   = cycle_ctr_q + 32'd1;
    event_count_d = event_count_q + 32'(push);
  end

  // Capture/drain state and free-running counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      bundle_q      <= '0;
      stamp_q       <= '0;
      cycle_ctr_q   <= '0;
      event_count_q <= '0;
    end else begin
      pending_q     <= pending_d;
      bundle_q      <= bundle_d;
      stamp_q       <= stamp_d;
      cycle_ctr_q   <= cycle_ctr_d;
      event_count_q <= event_count_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .push_rec (push_rec),
    .pop_i    (out_ready),
    .head     (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // stall_o depends only on registered state, never on the incoming bundle.
  assign stall_o     = (pending_q != '0) | fifo_full;
  assign out_valid   = !fifo_empty;
  assign out_kind    = head_rec.kind;
  assign out_pipe    = head_rec.pipe;
  assign out_addr    = head_rec.addr;
  assign out_data    = head_rec.data;
  assign out_cycle   = head_rec.cycle;
  assign event_count = event_count_q;

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Serializes the per-cycle architectural commit events of both issue pipes into an ordered record stream. The events are memory stores, GPR writes and HI/LO writes. It sits directly downstream of the writeback/memory stages of `trivial_mips` and feeds on-board trace readout (UART/JTAG bridge) or the bench's judge. Records come out in the same per-cycle order the judge uses: memA, reg1, hilo1, memB, reg2, hilo2. While draining a multi-event cycle it back-pressures the pipeline through `stall_o`, so no event is ever dropped.

## Interface
Parameters:
- `DEPTH`, 16: record FIFO depth, power of two, ≥2.

Ports:
- `clk`  in  1  core clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reg_wr1`, `reg_wr2`  in  `RegWriteReq_t`  pipe A/B GPR writes (`we`, `waddr`[4:0], `wdata`[31:0]).
- `hilo_wr1`, `hilo_wr2`  in  `HiloWriteReq_t`  pipe A/B HI/LO writes (`we`, `hilo`[63:0]).
- `mem_we_a`, `mem_we_b`  in  1  pipe A/B store commit.
- `mem_addr_a`, `mem_addr_b`  in  32  store byte addresses.
- `mem_data_a`, `mem_data_b`  in  32  store data.
- `stall_o`  out  1  pipeline must freeze commit; input bundle is ignored this cycle.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  consumer accepts the record.
- `out_kind`  out  2  0 = REG, 1 = HILO, 2 = MEM.
- `out_pipe`  out  1  0 = A, 1 = B.
- `out_addr`  out  16  REG: `waddr` zero-extended; HILO: 0; MEM: `addr[15:2]`, `2'b00`.
- `out_data`  out  64  REG/MEM: zero-extended 32-bit data; HILO: `{hi, lo}`.
- `out_cycle`  out  32  cycle stamp of the bundle that produced the record.
- `event_count`  out  32  total records written into the FIFO, wraps.

## Operation
- Slot vector, bit0 to bit5: memA, reg1 (`we && waddr != 0`), hilo1, memB, reg2 (`we && waddr != 0`), hilo2. Lower bit has higher priority.
- `cycle_ctr` resets to 0, increments every cycle and wraps from 2^32−1 to 0.
- Accept state (`pending == 0`):
  - If `!full` and the slot vector ≠ 0, capture the bundle: payloads into the slot registers, `stamp <= cycle_ctr`.
  - Write the lowest set slot into the FIFO the same cycle.
  - `pending <= vector & ~lowest`.
- Drain state (`pending != 0`):
  - Each cycle with `!full`, write the lowest pending slot from the slot registers and clear its bit.
  - If `full`, hold.
  - Inputs are ignored.
- `stall_o = (pending != 0) | full`. It is a combinational OR of registered state only, with no path from the inputs.
- Upstream contract: while `stall_o` is high, commit is held and the held bundle is re-presented. The block captures it only when `stall_o` is low.
- A bundle with N events therefore holds `stall_o` high for exactly N−1 cycles after capture, plus any cycles spent full.
- `event_count` increments on each FIFO write.
- FIFO write is gated by `!full`, using the registered count. A same-cycle pop does not free space for a same-cycle push.
- Output:
  - A record transfers when `out_valid && out_ready`.
  - All `out_*` fields hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid` 0, `stall_o` 0, `pending` 0, FIFO empty, `cycle_ctr` 0, `event_count` 0, `out_*` data 0.
- Reset asserted mid-drain flushes `pending` and the FIFO immediately. Records not yet transferred are lost; this is intended.
- Latency: a FIFO write in cycle t gives `out_valid` in cycle t+1 (registered FIFO head).
- With `out_ready` held at 1, the block emits one record per cycle, sustained.
- Empty bundles consume no cycles and never raise `stall_o`.

## Structure
- Shared `trace_pkg` contains:
  - `TraceKind_t` enum (REG/HILO/MEM).
  - `TraceRecord_t` struct {kind, pipe, addr[15:0], data[63:0], cycle[31:0]}.
  - `TRACE_SLOTS = 6`.
  - Slot-order constants.
- One sub-module, `trace_fifo`:
  - Synchronous FIFO of `TraceRecord_t`, `DEPTH` entries.
  - Registered head, `full`/`empty` from a `$clog2(DEPTH)+1`-bit count.
  - Reset is asynchronous, active-high.

## Test plan
- **Single reg write:** `reg_wr1 = {1, 5, 0x1234}` at cycle stamp 7, `out_ready = 1` → one record {REG, A, 0x0005, 0x1234, 7} on the next cycle; `stall_o` never rises.
- **Full bundle:** all six slots valid (memA addr 0x8000_0013, data 0xAA) → six records in order memA, reg1, hilo1, memB, reg2, hilo2, all with the same stamp. memA `out_addr` = 0x0010. `stall_o` is high for exactly 5 cycles.
- **Zero register:** `reg_wr2 = {1, 0, 0xFFFF}` alone → no record, `event_count` unchanged.
- **Backpressure:** `out_ready = 0`, 1-event bundles each cycle while `stall_o` is low.
  - After `DEPTH` records, `full` → `stall_o` = 1.
  - Then `out_ready = 1` for one cycle → exactly one record leaves; the held bundle is captured the cycle after.
  - Totals match; nothing is lost.
- **Reset mid-drain:** 4-event bundle, assert `rst` after 2 records → `out_valid` = 0 and `stall_o` = 0 immediately. After release, `cycle_ctr` restarts at 0.
- **Counter wrap:** force `cycle_ctr` = 0xFFFF_FFFF → records stamped 0xFFFF_FFFF then 0x0000_0000.
